// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder.
package systolic_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SWITCH,
    STREAM,
    DRAIN
  } feeder_state_t;

  // Low bit index of lane 'lane' inside a packed bus of 'width'-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew.sv
// skew_delay_line: DEPTH-stage zero-reset shift register that advances every cycle.
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads a weight tile, pulses the bank switch, then streams skewed input vectors and drains.
// Optional macro SYSTOLIC_FEEDER_STATS_EN adds stall_cnt (STREAM cycles with in_valid low, saturating).
module systolic_feeder #(
  parameter int ARRAY_WIDTH = 2,
  parameter int DATA_W      = 16,
  parameter int ROWS_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ROWS_W-1:0]             cmd_rows,
  input  logic [15:0]                   cmd_cols,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [ARRAY_WIDTH*DATA_W-1:0] w_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ARRAY_WIDTH*DATA_W-1:0] in_data,
  output logic [ARRAY_WIDTH*DATA_W-1:0] sys_data_in,
  output logic                          sys_start,
  output logic [ARRAY_WIDTH*DATA_W-1:0] sys_weight_in,
  output logic [ARRAY_WIDTH-1:0]        sys_accept_w,
  output logic                          sys_switch_in,
  output logic [15:0]                   ub_rd_col_size_out,
  output logic                          ub_rd_col_size_valid,
  output logic                          busy,
  output logic                          done
`ifdef SYSTOLIC_FEEDER_STATS_EN
  ,
  output logic [31:0]                   stall_cnt
`endif
);
  import systolic_pkg::*;

  localparam int LW = ARRAY_WIDTH * DATA_W;
  localparam logic [ROWS_W-1:0] LAST_LANE = ROWS_W'(ARRAY_WIDTH - 1);
  localparam logic [ROWS_W-1:0] ONE       = ROWS_W'(1);

  feeder_state_t     state, state_nxt;
  logic [ROWS_W-1:0] n_rows, cnt;
  logic [15:0]       cols, cols_clamped;
  logic [ARRAY_WIDTH-1:0] mask;
  logic [LW-1:0]     lane_mask, stream_in, skew_out;
  logic              cmd_fire, w_fire, in_fire;

  assign cmd_ready = (state == IDLE);
  assign w_ready   = (state == LOAD_W);
  assign in_ready  = (state == STREAM);
  assign busy      = (state != IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign w_fire    = w_valid && w_ready;
  assign in_fire   = in_valid && in_ready;

  assign cols_clamped = (cmd_cols > 16'(ARRAY_WIDTH)) ? 16'(ARRAY_WIDTH) : cmd_cols;

  for (genvar j = 0; j < ARRAY_WIDTH; j++) begin : g_mask
    assign mask[j] = (cols > 16'(j));
    assign lane_mask[lane_lo(j, DATA_W) +: DATA_W] = {DATA_W{mask[j]}};
  end

  // Idle cycles feed zeros so bubbles travel through the skew in step with data.
  assign stream_in = in_fire ? in_data : '0;
  assign skew_out[0 +: DATA_W] = stream_in[0 +: DATA_W];

  for (genvar r = 1; r < ARRAY_WIDTH; r++) begin : g_skew
    skew_delay_line #(
      .DEPTH (r),
      .DATA_W(DATA_W)
    ) u_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (stream_in[lane_lo(r, DATA_W) +: DATA_W]),
      .dout (skew_out[lane_lo(r, DATA_W) +: DATA_W])
    );
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nxt = LOAD_W;
      LOAD_W:  if (w_fire && cnt == LAST_LANE) state_nxt = SWITCH;
      SWITCH:  state_nxt = (n_rows == '0) ? IDLE : STREAM;
      STREAM:  if (in_fire && cnt == n_rows - ONE) state_nxt = DRAIN;
      // Drain lasts until the deepest lane's last element has left its output register.
      DRAIN:   if (cnt == LAST_LANE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      cnt                  <= '0;
      n_rows               <= '0;
      cols                 <= '0;
      ub_rd_col_size_out   <= '0;
      ub_rd_col_size_valid <= 1'b0;
      sys_data_in          <= '0;
      sys_start            <= 1'b0;
      sys_weight_in        <= '0;
      sys_accept_w         <= '0;
      sys_switch_in        <= 1'b0;
      done                 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (w_fire || in_fire || state == DRAIN) cnt <= cnt + ONE;
      ub_rd_col_size_valid <= cmd_fire;
      if (cmd_fire) begin
        n_rows             <= cmd_rows;
        cols               <= cols_clamped;
        ub_rd_col_size_out <= cols_clamped;
      end
      sys_data_in   <= skew_out;
      sys_start     <= in_fire;
      sys_weight_in <= w_fire ? (w_data & lane_mask) : '0;
      sys_accept_w  <= w_fire ? mask : '0;
      sys_switch_in <= (state == SWITCH);
      done          <= (state == SWITCH && n_rows == '0) ||
                       (state == DRAIN && cnt == LAST_LANE);
    end
  end

`ifdef SYSTOLIC_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || cmd_fire) stall_cnt <= '0;
    else if (state == STREAM && !in_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: cycle-indexed reference of handshakes vs. skewed/registered outputs.
module tb_systolic_feeder;
  localparam int AW = 2;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int LW = AW * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid, cmd_ready, w_valid, w_ready, in_valid, in_ready;
  logic [RW-1:0] cmd_rows;
  logic [15:0] cmd_cols, ub_rd_col_size_out;
  logic [LW-1:0] w_data, in_data, sys_data_in, sys_weight_in;
  logic [AW-1:0] sys_accept_w;
  logic sys_start, sys_switch_in, ub_rd_col_size_valid, busy, done;
`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  systolic_feeder #(.ARRAY_WIDTH(AW), .DATA_W(DW), .ROWS_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sys_data_in(sys_data_in), .sys_start(sys_start), .sys_weight_in(sys_weight_in),
    .sys_accept_w(sys_accept_w), .sys_switch_in(sys_switch_in),
    .ub_rd_col_size_out(ub_rd_col_size_out), .ub_rd_col_size_valid(ub_rd_col_size_valid),
    .busy(busy), .done(done)
`ifdef SYSTOLIC_FEEDER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] mask_of(input int cols);
    logic [AW-1:0] m;
    m = '0;
    for (int j = 0; j < AW; j++) if (j < cols) m[j] = 1'b1;
    return m;
  endfunction

  function automatic logic [LW-1:0] expand(input logic [AW-1:0] m);
    logic [LW-1:0] v;
    v = '0;
    for (int j = 0; j < AW; j++) if (m[j]) v[j*DW +: DW] = '1;
    return v;
  endfunction

  function automatic logic [DW-1:0] lane(input logic [LW-1:0] v, input int r);
    return v[r*DW +: DW];
  endfunction

  // Reference: handshake history keyed by cycle, plus scheduled switch/done events.
  logic [LW-1:0] in_hist [int];
  logic [LW-1:0] w_hist [int];
  logic [AW-1:0] am_hist [int];
  logic [15:0]   cmd_hist [int];
  bit sw_exp [int];
  bit done_exp [int];
  int cur_n, wb, ib;
  logic [AW-1:0] cur_mask;
  bit busy_m = 0, mon_en = 0;

  // Per-job captures for the directed checks.
  logic [AW-1:0] acc_or;
  bit saw_in_rdy;
  int sw_cnt, done_cnt, sw_cyc, done_cyc, acc_full_cnt;
  logic [15:0] cap_size;
  int l0_cyc[$], l1_cyc[$];
  logic [DW-1:0] l0_val[$], l1_val[$];

  always @(negedge clk) begin
    if (mon_en) begin
      logic [LW-1:0] ev;
      int cc;
      if (done_exp.exists(cyc)) busy_m = 0;
      ev = '0;
      for (int r = 0; r < AW; r++) begin
        cc = cyc - 1 - r;
        if (in_hist.exists(cc)) ev[r*DW +: DW] = lane(in_hist[cc], r);
      end
      chk("lanes", sys_data_in, ev);
      chk("start", sys_start, in_hist.exists(cyc - 1));
      chk("accept_w", sys_accept_w, w_hist.exists(cyc - 1) ? am_hist[cyc - 1] : '0);
      chk("weight", sys_weight_in, w_hist.exists(cyc - 1) ? w_hist[cyc - 1] : '0);
      chk("switch", sys_switch_in, sw_exp.exists(cyc));
      chk("done", done, done_exp.exists(cyc));
      chk("col_valid", ub_rd_col_size_valid, cmd_hist.exists(cyc - 1));
      if (cmd_hist.exists(cyc - 1)) chk("col_size", ub_rd_col_size_out, cmd_hist[cyc - 1]);
      chk("busy", busy, busy_m);
      chk("cmd_ready", cmd_ready, !busy_m);
      chk("rdy_excl", w_ready & in_ready, 1'b0);

      acc_or |= sys_accept_w;
      if (sys_accept_w == '1) acc_full_cnt++;
      if (in_ready) saw_in_rdy = 1;
      if (sys_switch_in) begin sw_cnt++; sw_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (ub_rd_col_size_valid) cap_size = ub_rd_col_size_out;
      if (lane(sys_data_in, 0) != 0) begin l0_cyc.push_back(cyc); l0_val.push_back(lane(sys_data_in, 0)); end
      if (lane(sys_data_in, 1) != 0) begin l1_cyc.push_back(cyc); l1_val.push_back(lane(sys_data_in, 1)); end

      if (!rst_n) begin
        in_hist.delete(); w_hist.delete(); am_hist.delete(); cmd_hist.delete();
        sw_exp.delete(); done_exp.delete();
        busy_m = 0; wb = 0; ib = 0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          cur_n = int'(cmd_rows);
          cmd_hist[cyc] = 16'((int'(cmd_cols) > AW) ? AW : int'(cmd_cols));
          cur_mask = mask_of(int'(cmd_cols));
          wb = 0; ib = 0; busy_m = 1;
        end
        if (w_valid && w_ready) begin
          w_hist[cyc] = w_data & expand(cur_mask);
          am_hist[cyc] = cur_mask;
          wb++;
          if (wb == AW) begin
            sw_exp[cyc + 2] = 1;
            if (cur_n == 0) done_exp[cyc + 2] = 1;
          end
        end
        if (in_valid && in_ready) begin
          in_hist[cyc] = in_data;
          ib++;
          if (ib == cur_n) done_exp[cyc + 1 + AW] = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    total++; bad++;
    $display("FAIL timeout %s cycle=%0d got=no_handshake expected=handshake", name, cyc);
  endtask

  task automatic send_cmd(input int n, input int cols);
    bit ok;
    ok = 0;
    cmd_rows = RW'(n); cmd_cols = 16'(cols); cmd_valid = 1;
    for (int k = 0; k < 60 && !ok; k++) begin @(negedge clk); ok = cmd_ready; tick(); end
    cmd_valid = 0; cmd_cols = 16'($urandom); cmd_rows = RW'($urandom);
    if (!ok) timeout("cmd");
  endtask

  task automatic send_w(input logic [LW-1:0] d, input int gap);
    bit ok;
    ok = 0;
    repeat (gap) tick();
    w_data = d; w_valid = 1;
    for (int k = 0; k < 60 && !ok; k++) begin @(negedge clk); ok = w_ready; tick(); end
    w_valid = 0; w_data = $urandom;
    if (!ok) timeout("w");
  endtask

  task automatic send_in(input logic [LW-1:0] d, input int gap);
    bit ok;
    ok = 0;
    repeat (gap) tick();
    in_data = d; in_valid = 1;
    for (int k = 0; k < 60 && !ok; k++) begin @(negedge clk); ok = in_ready; tick(); end
    in_valid = 0; in_data = $urandom;
    if (!ok) timeout("in");
  endtask

  logic [LW-1:0] w_q[$], in_q[$];
  int g_q[$];
  int w_gap_max = 0;

  task automatic clear_caps();
    acc_or = '0; saw_in_rdy = 0; sw_cnt = 0; done_cnt = 0; sw_cyc = -1; done_cyc = -1;
    acc_full_cnt = 0; cap_size = 16'hffff;
    l0_cyc.delete(); l1_cyc.delete(); l0_val.delete(); l1_val.delete();
  endtask

  task automatic fill_random(input int n);
    for (int b = 0; b < AW; b++) w_q.push_back($urandom);
    for (int i = 0; i < n; i++) begin in_q.push_back($urandom); g_q.push_back($urandom_range(0, 2)); end
  endtask

  task automatic run_job(input int n, input int cols);
    int exp_stall, g;
    bit ok;
    exp_stall = 0;
    clear_caps();
    send_cmd(n, cols);
`ifdef SYSTOLIC_FEEDER_STATS_EN
    chk("stall_clear", stall_cnt, 0);
`endif
    for (int b = 0; b < AW; b++) send_w(w_q.pop_front(), $urandom_range(0, w_gap_max));
    for (int i = 0; i < n; i++) begin
      g = g_q.pop_front();
      // The first gap cycle overlaps the switch cycle, before streaming starts.
      exp_stall += (i == 0) ? ((g > 0) ? g - 1 : 0) : g;
      send_in(in_q.pop_front(), g);
    end
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin @(negedge clk); ok = done; tick(); end
    if (!ok) timeout("done");
    tick();
`ifdef SYSTOLIC_FEEDER_STATS_EN
    chk("stall_cnt", stall_cnt, exp_stall);
`endif
  endtask

  task automatic check_skew_seq();
    logic [DW-1:0] e0[3], e1[3];
    e0 = '{16'd1, 16'd3, 16'd9};
    e1 = '{16'd2, 16'd4, 16'd10};
    chk("l0_count", l0_val.size(), 3);
    chk("l1_count", l1_val.size(), 3);
    chk("switch_once", sw_cnt, 1);
    chk("accept_full_cycles", acc_full_cnt, 2);
    if (l0_val.size() == 3 && l1_val.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("l0_val", l0_val[i], e0[i]);
        chk("l1_val", l1_val[i], e1[i]);
        chk("l1_skew", l1_cyc[i], l0_cyc[i] + 1);
      end
      chk("done_after_l1", done_cyc, l1_cyc[2] + 1);
    end
  endtask

  typedef struct {
    int n;
    int cols;
    logic [15:0] exp_size;
    logic [AW-1:0] exp_mask;
    bit exp_in_rdy;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{3, 2, 16'd2, 2'b11, 1'b1};
    tbl[1] = '{2, 5, 16'd2, 2'b11, 1'b1};
    tbl[2] = '{2, 1, 16'd1, 2'b01, 1'b1};
    tbl[3] = '{0, 2, 16'd2, 2'b11, 1'b0};
    tbl[4] = '{1, 0, 16'd0, 2'b00, 1'b1};
    tbl[5] = '{15, 2, 16'd2, 2'b11, 1'b1};

    cmd_valid = 0; w_valid = 0; in_valid = 0;
    cmd_rows = '0; cmd_cols = '0; w_data = '0; in_data = '0;
    clear_caps();
    repeat (2) tick();
    mon_en = 1;
    tick();
    rst_n = 1;
    tick();

    // Reset in the middle of streaming.
    send_cmd(10, 2);
    send_w(32'h0002_0001, 0);
    send_w(32'h0004_0003, 0);
    send_in(32'h0006_0005, 0);
    send_in(32'h0008_0007, 0);
    in_data = 32'h000a_0009; in_valid = 1; rst_n = 0;
    tick();
    rst_n = 1; in_valid = 0;
    @(negedge clk);
    chk("rst_data", sys_data_in, 0);
    chk("rst_start", sys_start, 0);
    chk("rst_weight", sys_weight_in, 0);
    chk("rst_accept", sys_accept_w, 0);
    chk("rst_switch", sys_switch_in, 0);
    chk("rst_colsize", ub_rd_col_size_out, 0);
    chk("rst_colvalid", ub_rd_col_size_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    tick();
    // Drain the partially applied skew lines before the directed jobs.
    repeat (4) tick();

    // Back-to-back stream with fixed weights.
    w_q = '{32'h0006_0005, 32'h0008_0007};
    in_q = '{32'h0002_0001, 32'h0004_0003, 32'h000a_0009};
    g_q = '{0, 0, 0};
    run_job(3, 2);
    check_skew_seq();
    chk("col_size_2", cap_size, 2);

    // Same stream with a two-cycle bubble between the first two vectors.
    w_q = '{32'h0006_0005, 32'h0008_0007};
    in_q = '{32'h0002_0001, 32'h0004_0003, 32'h000a_0009};
    g_q = '{0, 2, 0};
    run_job(3, 2);
    check_skew_seq();

    for (int i = 0; i < 6; i++) begin
      fill_random(tbl[i].n);
      run_job(tbl[i].n, tbl[i].cols);
      chk("tbl_col_size", cap_size, tbl[i].exp_size);
      chk("tbl_accept_mask", acc_or, tbl[i].exp_mask);
      chk("tbl_in_ready_seen", saw_in_rdy, tbl[i].exp_in_rdy);
      chk("tbl_switch_once", sw_cnt, 1);
      chk("tbl_done_once", done_cnt, 1);
      if (tbl[i].n == 0) chk("tbl_done_on_switch", done_cyc, sw_cyc);
    end

    w_gap_max = 2;
    for (int j = 0; j < 20; j++) begin
      int n, c;
      n = $urandom_range(0, 6);
      c = $urandom_range(0, 4);
      fill_random(n);
      run_job(n, c);
      chk("rnd_switch_once", sw_cnt, 1);
      chk("rnd_done_once", done_cnt, 1);
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
